// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder
// Parses UART command frames and hands the result to the SDRAM controller.
//   Write frame: WR_HDR, ADDR_BYTES address bytes (MSB first), length, payload.
//   Read frame : RD_HDR, ADDR_BYTES address bytes (MSB first), length.
// Optional build macro UART_CMD_CHECKSUM_EN: every frame carries a trailing
// checksum byte, which is the XOR of all earlier frame bytes including the header.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   rx_data           received byte, valid while flag_rx_end=1
//   flag_rx_end       single-cycle byte strobe
//   wfifo_full        write FIFO full; a payload byte arriving while full aborts the frame
//   wr_trig, rd_trig  one-cycle frame-complete pulses
//   cmd_addr, cmd_len address/length of the last completed frame
//   wfifo_wr_en/data  registered FIFO push
//   wfifo_flush       pulse: discard the partial payload of an aborted write frame
//   frame_err         pulse: frame aborted (bad length, FIFO full, checksum, timeout)
module uart_cmd_decoder #(
  parameter logic [7:0]  WR_HDR      = 8'hAA,
  parameter logic [7:0]  RD_HDR      = 8'hBB,
  parameter int unsigned ADDR_BYTES  = 2,
  parameter int unsigned LEN_MAX     = 16,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    flag_rx_end,
  input  logic                    wfifo_full,
  output logic                    wr_trig,
  output logic                    rd_trig,
  output logic [8*ADDR_BYTES-1:0] cmd_addr,
  output logic [7:0]              cmd_len,
  output logic                    wfifo_wr_en,
  output logic [7:0]              wfifo_wr_data,
  output logic                    wfifo_flush,
  output logic                    frame_err
);

  localparam int unsigned AW = 8 * ADDR_BYTES;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_DATA,
`ifdef UART_CMD_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic            wr_mode_q;
  logic [AW-1:0]   addr_q;
  logic [7:0]      len_q;
  logic [7:0]      cnt_q;
  logic [2:0]      acnt_q;
  logic [TW-1:0]   tmo_q;
`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]      csum_q;
`endif

  logic err_d, flush_d, done_d, push_d, tmo_hit;

  // A byte on the terminal-count cycle takes precedence over the timeout.
  assign tmo_hit = (state_q != S_IDLE) && (state_q != S_DONE) && !flag_rx_end &&
                   (tmo_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    push_d  = 1'b0;
    unique case (state_q)
      S_IDLE: if (flag_rx_end && (rx_data == WR_HDR || rx_data == RD_HDR)) state_d = S_ADDR;
      S_ADDR: if (flag_rx_end && acnt_q == 3'(ADDR_BYTES - 1)) state_d = S_LEN;
      S_LEN: if (flag_rx_end) begin
        if (rx_data == 8'd0 || rx_data > 8'(LEN_MAX)) err_d = 1'b1;
        else if (wr_mode_q) state_d = S_DATA;
        else begin
`ifdef UART_CMD_CHECKSUM_EN
          state_d = S_CSUM;
`else
          done_d = 1'b1;
`endif
        end
      end
      S_DATA: if (flag_rx_end) begin
        if (wfifo_full) err_d = 1'b1;
        else begin
          push_d = 1'b1;
          if (cnt_q + 8'd1 == len_q) begin
`ifdef UART_CMD_CHECKSUM_EN
            state_d = S_CSUM;
`else
            done_d = 1'b1;
`endif
          end
        end
      end
`ifdef UART_CMD_CHECKSUM_EN
      S_CSUM: if (flag_rx_end) begin
        if (rx_data == csum_q) done_d = 1'b1;
        else err_d = 1'b1;
      end
`endif
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (tmo_hit) err_d = 1'b1;
    if (err_d) state_d = S_IDLE;
    if (done_d) state_d = S_DONE;
    // cnt_q is nonzero only once a payload byte has been pushed (it stays
    // at len through the checksum byte), so it doubles as the flush qualifier.
    flush_d = err_d && wr_mode_q && (cnt_q != 8'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wr_mode_q     <= 1'b0;
      addr_q        <= '0;
      len_q         <= '0;
      cnt_q         <= '0;
      acnt_q        <= '0;
      tmo_q         <= '0;
`ifdef UART_CMD_CHECKSUM_EN
      csum_q        <= '0;
`endif
      wr_trig       <= 1'b0;
      rd_trig       <= 1'b0;
      cmd_addr      <= '0;
      cmd_len       <= '0;
      wfifo_wr_en   <= 1'b0;
      wfifo_wr_data <= '0;
      wfifo_flush   <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_trig     <= done_d && wr_mode_q;
      rd_trig     <= done_d && !wr_mode_q;
      frame_err   <= err_d;
      wfifo_flush <= flush_d;
      wfifo_wr_en <= push_d;
      if (push_d) wfifo_wr_data <= rx_data;
      // Loaded on the final-byte cycle so cmd_* change together with the trigger;
      // a read frame without checksum ends on its length byte.
      if (done_d) begin
        cmd_addr <= addr_q;
        cmd_len  <= (state_q == S_LEN) ? rx_data : len_q;
      end

      if (state_q == S_IDLE || flag_rx_end || state_d == S_IDLE) tmo_q <= '0;
      else tmo_q <= tmo_q + 1'b1;

      case (state_q)
        S_IDLE: begin
          acnt_q <= '0;
          cnt_q  <= '0;
          if (state_d == S_ADDR) begin
            wr_mode_q <= (rx_data == WR_HDR);
`ifdef UART_CMD_CHECKSUM_EN
            csum_q    <= rx_data;
`endif
          end
        end
        S_ADDR: if (flag_rx_end) begin
          addr_q <= AW'({addr_q, rx_data});
          acnt_q <= acnt_q + 3'd1;
`ifdef UART_CMD_CHECKSUM_EN
          csum_q <= csum_q ^ rx_data;
`endif
        end
        S_LEN: if (flag_rx_end) begin
          len_q <= rx_data;
`ifdef UART_CMD_CHECKSUM_EN
          csum_q <= csum_q ^ rx_data;
`endif
        end
        S_DATA: begin
          if (push_d) cnt_q <= cnt_q + 8'd1;
`ifdef UART_CMD_CHECKSUM_EN
          if (flag_rx_end) csum_q <= csum_q ^ rx_data;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
